// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter serialising core memory requests onto one single-port RAM
module mem_arbiter #(
    parameter int WIDTH       = 32,
    parameter int CORES       = 4,
    parameter int IDX         = 2,
    parameter int ADDR_WIDTH  = 16,
    parameter int RAM_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [CORES-1:0]        core_request,
    input  logic [CORES-1:0]        core_wren,
    input  logic [CORES*WIDTH-1:0]  core_address,
    input  logic [CORES*WIDTH-1:0]  core_writedata,
    output logic [WIDTH-1:0]        core_readdata,
    output logic [CORES-1:0]        core_response,
    output logic [IDX-1:0]          grant_idx,
    output logic [ADDR_WIDTH-1:0]   ram_address,
    output logic [WIDTH-1:0]        ram_writedata,
    output logic                    ram_wren,
    input  logic [WIDTH-1:0]        ram_readdata
);

    localparam int CNT_W = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RAM_LATENCY - 1);
    localparam logic [CORES-1:0] ONE_HOT0 = {{(CORES-1){1'b0}}, 1'b1};
    localparam logic [IDX-1:0]   LAST_CORE = IDX'(CORES - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                  state_q;
    logic [IDX-1:0]          prio_q;
    logic [IDX-1:0]          grant_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    wren_q;
    logic [WIDTH-1:0]        readdata_q;
    logic [CORES-1:0]        response_q;
    logic [ADDR_WIDTH-1:0]   ram_addr_q;
    logic [WIDTH-1:0]        ram_wdata_q;
    logic                    ram_wren_q;

    logic                    sel_found_d;
    logic [IDX-1:0]          sel_idx_d;
    logic [ADDR_WIDTH-1:0]   sel_addr_d;
    logic [WIDTH-1:0]        sel_wdata_d;
    logic                    sel_wren_d;

    // First requester at or after prio_q, wrapping modulo CORES.
    always_comb begin
        int k;
        sel_found_d = 1'b0;
        sel_idx_d   = '0;
        k           = 0;
        for (int i = 0; i < CORES; i++) begin
            k = (int'(prio_q) + i) % CORES;
            if (!sel_found_d && core_request[k]) begin
                sel_found_d = 1'b1;
                sel_idx_d   = IDX'(k);
            end
        end
    end

    assign sel_addr_d  = core_address[sel_idx_d*WIDTH +: ADDR_WIDTH];
    assign sel_wdata_d = core_writedata[sel_idx_d*WIDTH +: WIDTH];
    assign sel_wren_d  = core_wren[sel_idx_d];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            prio_q      <= '0;
            grant_q     <= '0;
            cnt_q       <= '0;
            wren_q      <= 1'b0;
            readdata_q  <= '0;
            response_q  <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_wren_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    response_q <= '0;
                    if (sel_found_d) begin
                        grant_q     <= sel_idx_d;
                        ram_addr_q  <= sel_addr_d;
                        ram_wdata_q <= sel_wdata_d;
                        wren_q      <= sel_wren_d;
                        ram_wren_q  <= sel_wren_d;
                        cnt_q       <= CNT_LOAD;
                        state_q     <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Strobe only in the first ACCESS cycle so a write lands once.
                    ram_wren_q <= 1'b0;
                    if (cnt_q == '0) begin
                        if (!wren_q) begin
                            readdata_q <= ram_readdata;
                        end
                        response_q <= ONE_HOT0 << grant_q;
                        state_q    <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    response_q <= '0;
                    prio_q     <= (grant_q == LAST_CORE) ? '0 : grant_q + 1'b1;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign core_readdata = readdata_q;
    assign core_response = response_q;
    assign grant_idx     = grant_q;
    assign ram_address   = ram_addr_q;
    assign ram_writedata = ram_wdata_q;
    assign ram_wren      = ram_wren_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a transaction-level arbitration model
module tb_mem_arbiter;

    localparam int W   = 32;
    localparam int NC  = 4;
    localparam int IW  = 2;
    localparam int AW  = 16;
    localparam int LAT = 2;
    localparam int PI  = (LAT > 1) ? LAT - 2 : 0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          start;
    } txn_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NC-1:0]     core_request = '0;
    logic [NC-1:0]     core_wren = '0;
    logic [NC*W-1:0]   core_address = '0;
    logic [NC*W-1:0]   core_writedata = '0;
    logic [W-1:0]      core_readdata;
    logic [NC-1:0]     core_response;
    logic [IW-1:0]     grant_idx;
    logic [AW-1:0]     ram_address;
    logic [W-1:0]      ram_writedata;
    logic              ram_wren;
    logic [W-1:0]      ram_readdata;

    mem_arbiter #(
        .WIDTH(W), .CORES(NC), .IDX(IW), .ADDR_WIDTH(AW), .RAM_LATENCY(LAT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .core_request(core_request),
        .core_wren(core_wren),
        .core_address(core_address),
        .core_writedata(core_writedata),
        .core_readdata(core_readdata),
        .core_response(core_response),
        .grant_idx(grant_idx),
        .ram_address(ram_address),
        .ram_writedata(ram_writedata),
        .ram_wren(ram_wren),
        .ram_readdata(ram_readdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM environment: data for the address seen in cycle c appears in cycle c+LAT-1.
    logic [31:0] mem [0:65535];
    logic [31:0] pipe [0:LAT-1];
    always @(posedge clk) begin
        if (ram_wren) mem[ram_address] <= ram_writedata;
        pipe[0] <= mem[ram_address];
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign ram_readdata = (LAT == 1) ? mem[ram_address] : pipe[PI];

    logic [31:0] ref_mem [0:65535];
    txn_t        exp_q [NC][$];

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: model state lives only here.
    int          m_free = 0;
    int          m_prio = 0;
    logic [31:0] m_last_rd = '0;
    int          wren_cnt = 0;
    logic [15:0] w_addr = '0;
    logic [31:0] w_data = '0;

    always @(negedge clk) begin
        if (reset) begin
            check("reset_outputs", {27'd0, |core_response, |core_readdata, |grant_idx,
                                    |ram_address, |ram_writedata} | {31'd0, ram_wren}, 32'd0);
            m_free    = cyc + 1;
            m_prio    = 0;
            m_last_rd = '0;
            wren_cnt  = 0;
        end else begin
            if (ram_wren) begin
                wren_cnt++;
                w_addr = ram_address;
                w_data = ram_writedata;
            end
            if (core_response != '0) begin
                int   k;
                int   min_start;
                int   s;
                int   expc;
                txn_t e;
                k = 0;
                for (int i = NC - 1; i >= 0; i--) if (core_response[i]) k = i;
                check("resp_onehot", {31'd0, $onehot(core_response)}, 32'd1);
                check("resp_expected", {31'd0, exp_q[k].size() != 0}, 32'd1);
                if (exp_q[k].size() != 0) begin
                    min_start = 32'h7fffffff;
                    for (int i = 0; i < NC; i++)
                        if (exp_q[i].size() != 0 && exp_q[i][0].start < min_start)
                            min_start = exp_q[i][0].start;
                    s = (m_free > min_start) ? m_free : min_start;
                    expc = -1;
                    for (int i = 0; i < NC; i++) begin
                        int c;
                        c = (m_prio + i) % NC;
                        if (expc < 0 && exp_q[c].size() != 0 && exp_q[c][0].start <= s) expc = c;
                    end
                    check("resp_cycle", cyc, s + LAT + 1);
                    check("served_core", k, expc);
                    check("grant_idx", {30'd0, grant_idx}, k);
                    e = exp_q[k].pop_front();
                    if (e.wr) begin
                        check("write_strobes", wren_cnt, 1);
                        check("write_addr", {16'd0, w_addr}, {16'd0, e.addr[15:0]});
                        check("write_data", w_data, e.data);
                        check("readdata_held", core_readdata, m_last_rd);
                        ref_mem[e.addr[15:0]] = e.data;
                    end else begin
                        check("read_strobes", wren_cnt, 0);
                        check("read_data", core_readdata, ref_mem[e.addr[15:0]]);
                        m_last_rd = ref_mem[e.addr[15:0]];
                    end
                end
                wren_cnt = 0;
                m_prio   = (k + 1) % NC;
                m_free   = cyc + 1;
            end
        end
    end

    // Stimulus side: a core drops its request in the cycle its response is seen.
    task automatic step();
        @(negedge clk);
        for (int k = 0; k < NC; k++)
            if (core_request[k] && core_response[k]) core_request[k] = 1'b0;
    endtask

    task automatic issue(input int k, input logic wr, input logic [31:0] a, input logic [31:0] d);
        txn_t e;
        core_wren[k]            = wr;
        core_address[k*W +: W]  = a;
        core_writedata[k*W +: W] = d;
        core_request[k]         = 1'b1;
        e.wr = wr; e.addr = a; e.data = d; e.start = cyc;
        exp_q[k].push_back(e);
    endtask

    function automatic bit any_pending();
        for (int k = 0; k < NC; k++) if (exp_q[k].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        while (n < 100 && any_pending()) begin
            step();
            n++;
        end
        vectors++;
        if (any_pending()) begin
            miscompares++;
            $display("FAIL idle_timeout: transactions still outstanding after %0d cycles, required none", n);
        end
        step();
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = (i * 32'h9E3779B1) ^ 32'h5A5A0000;
            ref_mem[i] = (i * 32'h9E3779B1) ^ 32'h5A5A0000;
        end
        mem[16'h0010]     = 32'hDEADBEEF;
        ref_mem[16'h0010] = 32'hDEADBEEF;
        for (int i = 0; i < LAT; i++) pipe[i] = '0;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Single read with address truncation.
        step();
        issue(1, 1'b0, 32'h0001_0010, 32'h0);
        wait_idle();

        // Write then read-back from another core.
        issue(2, 1'b1, 32'h0000_0020, 32'h1234_5678);
        wait_idle();
        issue(0, 1'b0, 32'h0000_0020, 32'h0);
        wait_idle();

        // Full contention, then rotation check.
        for (int k = 0; k < NC; k++) issue(k, 1'b0, 32'h0000_0030 + k, 32'h0);
        wait_idle();
        issue(2, 1'b0, 32'h0000_0040, 32'h0);
        wait_idle();
        issue(0, 1'b0, 32'h0000_0041, 32'h0);
        issue(3, 1'b0, 32'h0000_0042, 32'h0);
        wait_idle();

        // Reset in the second ACCESS cycle of a read; it must be re-served.
        issue(1, 1'b0, 32'h0000_0010, 32'h0);
        step();
        step();
        #2 reset = 1'b1;
        #1;
        check("async_reset_response", {28'd0, core_response}, 32'd0);
        check("async_reset_readdata", core_readdata, 32'd0);
        check("async_reset_ram", {15'd0, ram_wren, ram_address}, 32'd0);
        check("async_reset_wdata_grant", ram_writedata | {30'd0, grant_idx}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        wait_idle();

        // Randomized traffic over a small address window.
        for (int n = 0; n < 500; n++) begin
            step();
            for (int k = 0; k < NC; k++)
                if (!core_request[k] && $urandom_range(0, 3) == 0)
                    issue(k, 1'($urandom_range(0, 1)),
                          ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 31)), $urandom);
        end
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
